// File: rtl/stepdown_corestate_seq.sv
// Buck converter core-state sequencer: soft start, dead-time, minimum on-time,
// over-current latch-off. Optional zero-cross DCM idle state under STEPDOWN_ZCD_EN.
module stepdown_corestate_seq #(
  parameter int SS_CYC  = 32,
  parameter int OCP_MAX = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CELV,
  input  logic       CELG,
  input  logic       SUB,
  input  logic       en,
  input  logic       pwm_req,
  input  logic       ocp,
  input  logic       zcd,
  input  logic [3:0] dt_cfg,
  input  logic [7:0] ton_min_cfg,
  output logic       hs_on,
  output logic       ls_on,
  output logic       fault,
  output logic       ss_done,
  output logic [2:0] state
);

  localparam int SS_N  = (SS_CYC < 1) ? 1 : SS_CYC;
  localparam int OCP_N = (OCP_MAX < 1) ? 1 : OCP_MAX;
  localparam int SSW   = (SS_N > 1) ? $clog2(SS_N) : 1;
  localparam int OCW   = $clog2(OCP_N + 1);
  localparam logic [SSW-1:0] SS_LAST = SSW'(SS_N - 1);
  localparam logic [OCW-1:0] OCP_LIM = OCW'(OCP_N);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SS   = 3'd1,
    S_HS   = 3'd2,
    S_DHL  = 3'd3,
    S_LS   = 3'd4,
    S_DLH  = 3'd5,
    S_FLT  = 3'd6,
    S_DCM  = 3'd7
  } state_t;

  state_t           r_state;
  logic [SSW-1:0]   r_ss_cnt;
  logic [3:0]       r_dt_cnt;
  logic [3:0]       r_dt_lim;
  logic [7:0]       r_ton_cnt;
  logic [7:0]       r_ton_lim;
  logic [OCW-1:0]   r_ocp_cnt;
  logic             r_ss_done;

  logic [3:0]       w_dt_eff;
  logic [7:0]       w_ton_next;
  logic [OCW-1:0]   w_ocp_inc;
  logic             w_dead_done;
  logic             w_ton_met;
  logic             w_unused_pins;

`ifdef STEPDOWN_ZCD_EN
  assign w_unused_pins = CELV ^ CELG ^ SUB;
`else
  assign w_unused_pins = CELV ^ CELG ^ SUB ^ zcd;
`endif

  assign w_dt_eff    = (dt_cfg == 4'd0) ? 4'd1 : dt_cfg;
  assign w_ton_next  = (r_ton_cnt == 8'hFF) ? 8'hFF : r_ton_cnt + 8'd1;
  assign w_ocp_inc   = r_ocp_cnt + OCW'(1);
  // Dead limits are loaded with a value of at least 1, so lim-1 never wraps in use.
  assign w_dead_done = (r_dt_cnt == r_dt_lim - 4'd1);
  assign w_ton_met   = (w_ton_next >= r_ton_lim);

  always_ff @(posedge CLK) begin
    if (RST || !en) begin
      r_state   <= S_IDLE;
      r_ss_cnt  <= '0;
      r_dt_cnt  <= '0;
      r_dt_lim  <= '0;
      r_ton_cnt <= '0;
      r_ton_lim <= '0;
      r_ocp_cnt <= '0;
      r_ss_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ss_cnt  <= '0;
          r_ss_done <= 1'b0;
          r_state   <= S_SS;
        end
        S_SS: begin
          if (r_ss_cnt == SS_LAST) begin
            r_ss_done <= 1'b1;
            r_dt_cnt  <= '0;
            r_dt_lim  <= w_dt_eff;
            r_state   <= S_DLH;
          end else begin
            r_ss_cnt <= r_ss_cnt + SSW'(1);
          end
        end
        S_DLH: begin
          if (w_dead_done) begin
            r_ton_cnt <= '0;
            r_ton_lim <= ton_min_cfg;
            r_state   <= S_HS;
          end else begin
            r_dt_cnt <= r_dt_cnt + 4'd1;
          end
        end
        S_HS: begin
          r_ton_cnt <= w_ton_next;
          // Over-current cuts the pulse short regardless of the minimum on-time.
          if (ocp) begin
            r_ocp_cnt <= w_ocp_inc;
            if (w_ocp_inc >= OCP_LIM) begin
              r_state <= S_FLT;
            end else begin
              r_dt_cnt <= '0;
              r_dt_lim <= w_dt_eff;
              r_state  <= S_DHL;
            end
          end else if (!pwm_req && w_ton_met) begin
            r_ocp_cnt <= '0;
            r_dt_cnt  <= '0;
            r_dt_lim  <= w_dt_eff;
            r_state   <= S_DHL;
          end
        end
        S_DHL: begin
          if (w_dead_done) begin
            r_state <= S_LS;
          end else begin
            r_dt_cnt <= r_dt_cnt + 4'd1;
          end
        end
        S_LS: begin
          if (pwm_req) begin
            r_dt_cnt <= '0;
            r_dt_lim <= w_dt_eff;
            r_state  <= S_DLH;
          end
`ifdef STEPDOWN_ZCD_EN
          else if (zcd) begin
            r_state <= S_DCM;
          end
`endif
        end
        S_FLT: begin
          r_state <= S_FLT;
        end
        S_DCM: begin
`ifdef STEPDOWN_ZCD_EN
          if (pwm_req) begin
            r_dt_cnt <= '0;
            r_dt_lim <= w_dt_eff;
            r_state  <= S_DLH;
          end
`else
          r_ss_done <= 1'b0;
          r_state   <= S_IDLE;
`endif
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign state   = r_state;
  assign hs_on   = (r_state == S_HS);
  assign ls_on   = (r_state == S_LS);
  assign fault   = (r_state == S_FLT);
  assign ss_done = r_ss_done;

endmodule

// File: tb/tb_stepdown_corestate_seq.sv
// Bench for stepdown_corestate_seq: vector table, corner sequences, and random
// stimulus against a time-in-state reference model.
module tb_stepdown_corestate_seq;

  localparam int SS_CYC  = 32;
  localparam int OCP_MAX = 4;
`ifdef STEPDOWN_ZCD_EN
  localparam bit ZCD_ON = 1'b1;
`else
  localparam bit ZCD_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, en, pwm_req, ocp, zcd;
  logic [3:0] dt_cfg;
  logic [7:0] ton_min_cfg;
  logic       hs_on, ls_on, fault, ss_done;
  logic [2:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  stepdown_corestate_seq #(.SS_CYC(SS_CYC), .OCP_MAX(OCP_MAX)) dut (
    .CLK(clk), .RST(rst), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
    .en(en), .pwm_req(pwm_req), .ocp(ocp), .zcd(zcd),
    .dt_cfg(dt_cfg), .ton_min_cfg(ton_min_cfg),
    .hs_on(hs_on), .ls_on(ls_on), .fault(fault), .ss_done(ss_done), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       pwm;
    logic       ocp;
    logic [3:0] dt;
    logic [7:0] ton;
    logic [7:0] n;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs [0:31];
  int   nv = 0;

  // Reference model: phase number plus cycles spent in it and the dwell sampled on entry.
  int m_st = 0, m_age = 0, m_dwell = 0, m_ocp = 0;
  bit m_ssd = 0;

  function automatic logic [6:0] exp_of(input int st, input logic ssd);
    return {3'(st), st == 2, st == 4, st == 6, ssd};
  endfunction

  task automatic add(input logic r, input logic e, input logic p, input logic o,
                     input logic [3:0] dt, input logic [7:0] ton, input int n,
                     input int st, input logic ssd);
    vec_t v;
    v.rst = r; v.en = e; v.pwm = p; v.ocp = o; v.dt = dt; v.ton = ton;
    v.n = 8'(n); v.exp = exp_of(st, ssd);
    vecs[nv] = v;
    nv++;
  endtask

  task automatic drive(input logic r, input logic e, input logic p, input logic o,
                       input logic z, input logic [3:0] dt, input logic [7:0] ton);
    rst = r; en = e; pwm_req = p; ocp = o; zcd = z; dt_cfg = dt; ton_min_cfg = ton;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] got;
    got = {state, hs_on, ls_on, fault, ss_done};
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b want %b (state,hs,ls,fault,ss_done)", name, got, exp);
  endtask

  task automatic wait_state(input string name, input logic [2:0] tgt, input int budget);
    int n;
    n = 0;
    while (state !== tgt && n < budget) begin
      tick();
      n++;
    end
    n_checks++;
    if (state === tgt) n_pass++;
    else $display("FAIL %s: state %0d after %0d cycles, want %0d", name, state, n, tgt);
  endtask

  task automatic model_step(input bit r, input bit e, input bit p, input bit o,
                            input bit z, input int dt, input int ton);
    int nxt;
    if (r || !e) begin
      m_st = 0; m_age = 0; m_ocp = 0; m_ssd = 0;
      return;
    end
    m_age++;
    nxt = m_st;
    case (m_st)
      0: nxt = 1;
      1: if (m_age == SS_CYC) begin nxt = 5; m_ssd = 1; end
      5: if (m_age >= m_dwell) nxt = 2;
      3: if (m_age >= m_dwell) nxt = 4;
      2: begin
        if (o) begin
          m_ocp++;
          nxt = (m_ocp >= OCP_MAX) ? 6 : 3;
        end else if (!p && m_age >= m_dwell) begin
          m_ocp = 0;
          nxt = 3;
        end
      end
      4: if (p) nxt = 5; else if (ZCD_ON && z) nxt = 7;
      7: if (!ZCD_ON) nxt = 0; else if (p) nxt = 5;
      default: ;
    endcase
    if (nxt != m_st) begin
      m_age = 0;
      if (nxt == 3 || nxt == 5) m_dwell = (dt == 0) ? 1 : dt;
      if (nxt == 2) m_dwell = ton;
      if (nxt == 0) m_ssd = 0;
    end
    m_st = nxt;
  endtask

  initial begin
    // rst, en, pwm, ocp, dt, ton, cycles, expected state, expected ss_done
    add(1, 0, 1, 0, 3, 5,  2, 0, 0);
    add(0, 0, 1, 0, 3, 5,  1, 0, 0);
    add(0, 1, 1, 0, 3, 5,  1, 1, 0);
    add(0, 1, 1, 0, 3, 5, 31, 1, 0);
    add(0, 1, 1, 0, 3, 5,  1, 5, 1);
    add(0, 1, 1, 0, 3, 5,  2, 5, 1);
    add(0, 1, 1, 0, 3, 5,  1, 2, 1);
    add(0, 1, 1, 0, 3, 5,  1, 2, 1);
    add(0, 1, 0, 0, 3, 5,  3, 2, 1);
    add(0, 1, 0, 0, 3, 5,  1, 3, 1);
    add(0, 1, 0, 0, 3, 5,  2, 3, 1);
    add(0, 1, 0, 0, 3, 5,  1, 4, 1);
    add(0, 1, 1, 0, 3, 5,  1, 5, 1);
    add(0, 1, 1, 0, 3, 5,  3, 2, 1);
    for (int k = 0; k < 3; k++) begin
      add(0, 1, 1, 1, 3, 5, 1, 3, 1);
      add(0, 1, 1, 0, 3, 5, 3, 4, 1);
      add(0, 1, 1, 0, 3, 5, 1, 5, 1);
      add(0, 1, 1, 0, 3, 5, 3, 2, 1);
    end
    add(0, 1, 1, 1, 3, 5,  1, 6, 1);
    add(0, 1, 1, 0, 3, 5,  5, 6, 1);
    add(0, 0, 1, 0, 3, 5,  1, 0, 0);

    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < nv; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].pwm, vecs[i].ocp, 1'b0, vecs[i].dt, vecs[i].ton);
      for (int c = 0; c < int'(vecs[i].n); c++) tick();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Zero dead-time: exactly one both-off cycle at each switch transition.
    drive(0, 1, 1, 0, 0, 0, 0);
    wait_state("dt0_reach_hs", 3'd2, 60);
    pwm_req = 0; tick(); check("dt0_hs_to_dhl", exp_of(3, 1));
    tick();              check("dt0_ls_on", exp_of(4, 1));
    pwm_req = 1; tick(); check("dt0_ls_to_dlh", exp_of(5, 1));
    tick();              check("dt0_hs_on", exp_of(2, 1));

    pwm_req = 0; tick(); check("zcd_hs_off", exp_of(3, 1));
    tick();              check("zcd_ls_on", exp_of(4, 1));
    zcd = 1; tick();
    if (ZCD_ON) check("zcd_enter_dcm", exp_of(7, 1));
    else        check("zcd_ignored", exp_of(4, 1));
    zcd = 0; pwm_req = 1; tick(); check("zcd_leave", exp_of(5, 1));

    tick();              check("rst_mid_hs", exp_of(2, 1));
    rst = 1; tick();     check("rst_applied", exp_of(0, 0));

    drive(0, 1, 1, 0, 0, 2, 3);
    wait_state("en0_reach_hs", 3'd2, 60);
    en = 0; ocp = 1; tick(); check("en0_beats_ocp", exp_of(0, 0));

    // Randomised run against the reference model.
    drive(1, 0, 0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0, 0, 0);
    tick();
    check("rand_reset", exp_of(m_st, m_ssd));
    for (int i = 0; i < 2500; i++) begin
      logic r, e, p, o, z;
      logic [3:0] d;
      logic [7:0] t;
      r = ($urandom_range(0, 399) == 0);
      e = ($urandom_range(0, 149) != 0);
      p = ($urandom_range(0, 3) == 0) ? ~pwm_req : pwm_req;
      o = ($urandom_range(0, 3) == 0);
      z = 1'($urandom_range(0, 1));
      d = 4'($urandom_range(0, 3));
      t = 8'($urandom_range(0, 6));
      drive(r, e, p, o, z, d, t);
      model_step(r, e, p, o, z, int'(d), int'(t));
      tick();
      check($sformatf("rand%0d", i), exp_of(m_st, m_ssd));
      n_checks++;
      if (!(hs_on && ls_on)) n_pass++;
      else $display("FAIL overlap%0d: hs_on=%b ls_on=%b, want not both 1", i, hs_on, ls_on);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
